// File: rtl/unary_pkg.sv
// rtl/unary_pkg.sv - shared unary-domain FSM encodings and result width helper
package unary_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } unaryStateT;

  // Bipolar results need one extra sign bit to cover -N..N.
  function automatic int unaryOutWidth(input int winLog2);
`ifdef UNARY_WINDOW_BIPOLAR_EN
    return winLog2 + 2;
`else
    return winLog2 + 1;
`endif
  endfunction

endpackage

// File: rtl/unary_sample_counter.sv
// rtl/unary_sample_counter.sv - WIN_LOG2-bit sample counter with clear, enable and terminal flag
module unary_sample_counter #(
  parameter int WIN_LOG2 = 4
) (
  input  logic iClk,
  input  logic iRstN,
  input  logic iClr,
  input  logic iEn,
  output logic oTerm
);

  logic [WIN_LOG2-1:0] cntQ;

  // Natural wrap at the terminal count restarts the next window from zero.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      cntQ <= '0;
    end else if (iClr) begin
      cntQ <= '0;
    end else if (iEn) begin
      cntQ <= cntQ + WIN_LOG2'(1);
    end
  end

  assign oTerm = (cntQ == {WIN_LOG2{1'b1}});

endmodule

// File: rtl/unary_window_counter.sv
// rtl/unary_window_counter.sv - counts 1s of a unary bitstream over 2^WIN_LOG2 valid samples
// Build option UNARY_WINDOW_BIPOLAR_EN: result as signed 2*ones-N instead of unsigned ones.
module unary_window_counter
  import unary_pkg::*;
#(
  parameter  int WIN_LOG2 = 4,
  localparam int OUT_W    = unaryOutWidth(WIN_LOG2)
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iClr,
  input  logic             iStart,
  input  logic             iBit,
  input  logic             iBitValid,
  output logic             oBusy,
  output logic             oValid,
  output logic [OUT_W-1:0] oData
);

  localparam int N = 1 << WIN_LOG2;

  unaryStateT          stateQ, stateD;
  logic [WIN_LOG2:0]   onesQ;
  logic [WIN_LOG2:0]   finalOnes;
  logic [OUT_W-1:0]    dataQ, dataD;
  logic                accept, lastSample, startWin, sampleTerm;

  assign accept     = (stateQ == COUNT) && iBitValid;
  assign lastSample = accept && sampleTerm;
  assign startWin   = iStart && ((stateQ == IDLE) || (stateQ == DONE));
  assign finalOnes  = onesQ + {{WIN_LOG2{1'b0}}, iBit};

  unary_sample_counter #(.WIN_LOG2(WIN_LOG2)) uSampleCnt (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iClr  (iClr || startWin),
    .iEn   (accept),
    .oTerm (sampleTerm)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      stateQ <= IDLE;
    end else if (iClr) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (iStart) stateD = COUNT;
      COUNT:   if (lastSample) stateD = DONE;
      DONE:    stateD = iStart ? COUNT : IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
`ifdef UNARY_WINDOW_BIPOLAR_EN
    dataD = (OUT_W'(finalOnes) << 1) - OUT_W'(N);
`else
    dataD = finalOnes;
`endif
  end

  // The result includes the sample accepted on the completing edge.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      onesQ <= '0;
      dataQ <= '0;
    end else if (iClr) begin
      onesQ <= '0;
      dataQ <= '0;
    end else begin
      if (startWin) begin
        onesQ <= '0;
      end else if (accept) begin
        onesQ <= finalOnes;
      end
      if (lastSample) begin
        dataQ <= dataD;
      end
    end
  end

  always_comb begin
    oBusy  = (stateQ == COUNT);
    oValid = (stateQ == DONE);
    oData  = dataQ;
  end

endmodule

// File: tb/tb_unary_window_counter.sv
// tb/tb_unary_window_counter.sv - directed self-checking bench for unary_window_counter (N=16)
module tb_unary_window_counter;

`ifdef UNARY_WINDOW_BIPOLAR_EN
  localparam int OW = 6;
`else
  localparam int OW = 5;
`endif

  logic          iClk = 1'b0;
  logic          iRstN, iClr, iStart, iBit, iBitValid;
  logic          oBusy, oValid;
  logic [OW-1:0] oData;
  int            nCompared = 0;
  int            nMismatched = 0;
  int            cycle = 0;
  int            startCycle;

  always #5 iClk = ~iClk;
  always @(posedge iClk) cycle <= cycle + 1;

  unary_window_counter #(.WIN_LOG2(4)) dut (
    .iClk      (iClk),
    .iRstN     (iRstN),
    .iClr      (iClr),
    .iStart    (iStart),
    .iBit      (iBit),
    .iBitValid (iBitValid),
    .oBusy     (oBusy),
    .oValid    (oValid),
    .oData     (oData)
  );

  task automatic checkVal(input string tag, input int obs, input int exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int expData(input int ones);
`ifdef UNARY_WINDOW_BIPOLAR_EN
    return 2 * ones - 16;
`else
    return ones;
`endif
  endfunction

  function automatic int dataVal();
`ifdef UNARY_WINDOW_BIPOLAR_EN
    return int'($signed(oData));
`else
    return int'(oData);
`endif
  endfunction

  task automatic startWin();
    @(negedge iClk);
    iStart = 1'b1;
    startCycle = cycle;
    @(negedge iClk);
    iStart = 1'b0;
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      iBitValid = 1'b1;
      iBit = bits[i];
      @(negedge iClk);
    end
    iBitValid = 1'b0;
    iBit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    iRstN = 1'b0; iClr = 1'b0; iStart = 1'b0; iBit = 1'b0; iBitValid = 1'b0;
    repeat (3) @(negedge iClk);
    checkVal("rst_busy", oBusy, 0);
    checkVal("rst_valid", oValid, 0);
    checkVal("rst_data", dataVal(), 0);
    iRstN = 1'b1;

    // 1: sixteen ones, latency from start
    startWin();
    checkVal("t1_busy", oBusy, 1);
    feed(16'hFFFF, 16);
    checkVal("t1_valid", oValid, 1);
    checkVal("t1_latency", cycle - startCycle, 17);
    checkVal("t1_data", dataVal(), expData(16));
    checkVal("t1_busy_done", oBusy, 0);
    @(negedge iClk);
    checkVal("t1_pulse", oValid, 0);
    checkVal("t1_hold", dataVal(), expData(16));

    // 2: alternating and all zeros
    startWin();
    feed(16'hAAAA, 16);
    checkVal("t2_alt_valid", oValid, 1);
    checkVal("t2_alt_data", dataVal(), expData(8));
    startWin();
    feed(16'h0000, 16);
    checkVal("t2_zero_data", dataVal(), expData(0));

    // 3: 16 valid samples over 24 cycles, 5 ones, iBit high on invalid cycles
    startWin();
    begin
      int k = 0;
      for (int i = 0; i < 24; i++) begin
        iBitValid = (i % 3 != 0);
        iBit = iBitValid ? (k < 5) : 1'b1;
        if (iBitValid) k++;
        @(negedge iClk);
        if (i == 22) checkVal("t3_no_early_valid", oValid, 0);
      end
      iBitValid = 1'b0; iBit = 1'b0;
    end
    checkVal("t3_valid", oValid, 1);
    checkVal("t3_data", dataVal(), expData(5));

    // 4: clear after 7 samples aborts the window
    startWin();
    feed(16'hFFFF, 7);
    iClr = 1'b1;
    @(negedge iClk);
    iClr = 1'b0;
    checkVal("t4_clr_busy", oBusy, 0);
    checkVal("t4_clr_valid", oValid, 0);
    checkVal("t4_clr_data", dataVal(), 0);
    feed(16'hFFFF, 12);
    checkVal("t4_idle_no_valid", oValid, 0);
    checkVal("t4_idle_busy", oBusy, 0);
    startWin();
    feed(16'hFFFF, 16);
    checkVal("t4_data", dataVal(), expData(16));

    // 5: back-to-back windows; iStart held through COUNT has no effect
    startWin();
    iStart = 1'b1;
    feed(16'h0007, 16);
    checkVal("t5_a_valid", oValid, 1);
    checkVal("t5_a_data", dataVal(), expData(3));
    @(negedge iClk);
    iStart = 1'b0;
    checkVal("t5_b_busy", oBusy, 1);
    checkVal("t5_b_hold", dataVal(), expData(3));
    feed(16'h0FFF, 16);
    checkVal("t5_b_valid", oValid, 1);
    checkVal("t5_b_data", dataVal(), expData(12));

    // 6: asynchronous reset mid-window
    startWin();
    feed(16'hFFFF, 5);
    #2 iRstN = 1'b0;
    #1;
    checkVal("t6_rst_busy", oBusy, 0);
    checkVal("t6_rst_valid", oValid, 0);
    checkVal("t6_rst_data", dataVal(), 0);
    @(negedge iClk);
    iRstN = 1'b1;
    @(negedge iClk);
    checkVal("t6_idle", oBusy, 0);
    startWin();
    feed(16'h5555, 16);
    checkVal("t6_valid", oValid, 1);
    checkVal("t6_data", dataVal(), expData(8));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
